ctrl_pipe: RTL and testbench
============================

// Module: ctrl_pipe
// PURPOSE
//  Consumer end of the 8-bit control bundle produced by the main decoder at ID.
//  Carries the bundle and register specifiers through the ID/EX, EX/MEM and MEM/WB
//  stage registers and unpacks the fields at the stage that uses them.
//  Detects load-use hazards (stall plus bubble) and generates the EX forwarding selects.
//  Sits between the ID stage, the datapath stage muxes and the register file.
// PARAMETERS
//  REG_W   5  register-specifier width
//  CTRL_W  8  control bundle width
// PORTS
//  clk_i           in   1       clock, rising edge
//  rst_i           in   1       reset; one clock, synchronous, active-low
//  ctrl_i          in   CTRL_W  {RegWrite,MemtoReg,MemRead,MemWrite,ALUSrc,ALUOp[1:0],RegDst} from ID, bit7..bit0
//  rs_i            in   REG_W   ID rs field
//  rt_i            in   REG_W   ID rt field
//  rd_i            in   REG_W   ID rd field
//  flush_i         in   1       ID instruction squashed (branch taken or jump)
//  pc_write_o      out  1       PC update enable
//  ifid_write_o    out  1       IF/ID register write enable
//  stall_o         out  1       load-use stall indicator
//  ex_alusrc_o     out  1       EX ALU B-source select
//  ex_aluop_o      out  2       EX ALUOp
//  ex_rs_o         out  REG_W   EX rs
//  ex_rt_o         out  REG_W   EX rt
//  ex_dst_o        out  REG_W   EX destination (RegDst ? rd : rt)
//  fwd_a_o         out  2       ALU A forward select
//  fwd_b_o         out  2       ALU B forward select
//  mem_memread_o   out  1       MEM stage read enable
//  mem_memwrite_o  out  1       MEM stage write enable
//  mem_regwrite_o  out  1       MEM stage RegWrite
//  mem_dst_o       out  REG_W   MEM stage destination register
//  wb_regwrite_o   out  1       register-file write enable
//  wb_memtoreg_o   out  1       WB data select
//  wb_dst_o        out  REG_W   register-file write address
// BEHAVIOUR
//  - Reset (rst_i=0 at a clock edge): all ID/EX, EX/MEM and MEM/WB fields clear to 0, i.e. a bubble.
//    Consequences: every stage output reads 0, fwd_a_o=fwd_b_o=00, stall_o=0, pc_write_o=ifid_write_o=1.
//  - Reset mid-operation discards all in-flight instructions. No wb_regwrite_o pulse follows the reset.
//  - Register chain: ID->EX->MEM->WB advances every cycle. EX/MEM and MEM/WB never stall.
//  - Latency: a bundle sampled at edge N appears at EX after edge N, at MEM after N+1 and at WB after N+2.
//  - ex_dst is computed at ID/EX capture from RegDst, and is carried forward unchanged to mem_dst and wb_dst.
//  - load_use = ex_memread & (ex_rt != 0) & ((ex_rt == rs_i) | (ex_rt == rt_i)).
//  - stall_o = load_use & ~flush_i. It is combinational from the EX registers and the ID inputs.
//  - pc_write_o = ifid_write_o = ~stall_o.
//  - ID/EX capture:
//      * If stall_o or flush_i is 1: the whole ID/EX register, control bits and specifiers alike, loads 0 (bubble).
//      * Otherwise it loads ctrl_i, rs_i, rt_i and the computed dst.
//  - A stall lasts exactly one cycle per load. After the bubble, the dependent instruction takes its data through the WB forward path.
//  - Forwarding (fwd_a_o, evaluated against ex_rs; fwd_b_o identical against ex_rt):
//      * 10 if mem_regwrite & mem_dst != 0 & mem_dst == ex_rs
//      * else 01 if wb_regwrite & wb_dst != 0 & wb_dst == ex_rs
//      * else 00
//      * When both stages match, MEM has priority.
//  - Writes to register 0 never forward and never stall.
//  - x on ctrl_i bits 6, 3, 2, 1 or 0 (jump encoding) is tolerated. Bits 7, 5 and 4 must be known when flush_i=0.
// TESTING
//  1. Reset: rst_i=0 for 2 cycles with ctrl_i=8'hFF -> all stage outputs 0, pc_write_o=1, stall_o=0.
//  2. R-type: ctrl_i=8'h87, rs=1, rt=2, rd=3 -> +1: ex_aluop_o=11, ex_dst_o=3; +2: mem_regwrite_o=1, mem_dst_o=3; +3: wb_regwrite_o=1, wb_dst_o=3.
//  3. Load-use: lw 8'hE8 rt=5, then R-type rs=5 -> stall_o=1 and pc_write_o=0 for exactly one cycle, EX holds a bubble, then the R-type reaches EX with fwd_a_o=01.
//  4. Forward: R-type rd=4, then R-type rs=4 rt=4 -> fwd_a_o=fwd_b_o=10. Repeat with rd=0 -> 00.
//  5. Flush: ctrl_i=8'h87, flush_i=1 -> next cycle all EX outputs 0. lw in EX plus a hazard in ID with flush_i=1 -> stall_o=0.
//  6. Mid-run reset: pipeline holding sw(8'h18), lw and R-type; rst_i=0 for one edge -> all outputs 0 and no wb_regwrite_o afterward.

Source files
------------

// File: rtl/ctrl_pipe.sv
// Control-side pipeline from ID to WB: carries the decoder bundle and register specifiers
// through ID/EX, EX/MEM and MEM/WB, detects load-use hazards and produces EX forward selects.
module ctrl_pipe #(
    parameter int REG_W  = 5,
    parameter int CTRL_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [REG_W-1:0]  rs_i,
    input  logic [REG_W-1:0]  rt_i,
    input  logic [REG_W-1:0]  rd_i,
    input  logic              flush_i,
    output logic              pc_write_o,
    output logic              ifid_write_o,
    output logic              stall_o,
    output logic              ex_alusrc_o,
    output logic [1:0]        ex_aluop_o,
    output logic [REG_W-1:0]  ex_rs_o,
    output logic [REG_W-1:0]  ex_rt_o,
    output logic [REG_W-1:0]  ex_dst_o,
    output logic [1:0]        fwd_a_o,
    output logic [1:0]        fwd_b_o,
    output logic              mem_memread_o,
    output logic              mem_memwrite_o,
    output logic              mem_regwrite_o,
    output logic [REG_W-1:0]  mem_dst_o,
    output logic              wb_regwrite_o,
    output logic              wb_memtoreg_o,
    output logic [REG_W-1:0]  wb_dst_o
);

    localparam int B_REGWRITE = 7;
    localparam int B_MEMTOREG = 6;
    localparam int B_MEMREAD  = 5;
    localparam int B_MEMWRITE = 4;
    localparam int B_ALUSRC   = 3;
    localparam int B_REGDST   = 0;

    logic             ex_regwrite_reg, ex_memtoreg_reg, ex_memread_reg, ex_memwrite_reg;
    logic             ex_alusrc_reg;
    logic [1:0]       ex_aluop_reg;
    logic [REG_W-1:0] ex_rs_reg, ex_rt_reg, ex_dst_reg;

    logic             mem_regwrite_reg, mem_memtoreg_reg, mem_memread_reg, mem_memwrite_reg;
    logic [REG_W-1:0] mem_dst_reg;

    logic             wb_regwrite_reg, wb_memtoreg_reg;
    logic [REG_W-1:0] wb_dst_reg;

    logic             load_use;
    logic             stall;
    logic             bubble;
    logic [REG_W-1:0] id_dst;

    assign load_use = ex_memread_reg && (ex_rt_reg != '0) &&
                      ((ex_rt_reg == rs_i) || (ex_rt_reg == rt_i));
    // A squashed ID instruction cannot depend on anything, so flush suppresses the stall.
    assign stall    = load_use && !flush_i;
    assign bubble   = stall || flush_i;
    assign id_dst   = ctrl_i[B_REGDST] ? rd_i : rt_i;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            ex_regwrite_reg  <= 1'b0;
            ex_memtoreg_reg  <= 1'b0;
            ex_memread_reg   <= 1'b0;
            ex_memwrite_reg  <= 1'b0;
            ex_alusrc_reg    <= 1'b0;
            ex_aluop_reg     <= 2'b00;
            ex_rs_reg        <= '0;
            ex_rt_reg        <= '0;
            ex_dst_reg       <= '0;
            mem_regwrite_reg <= 1'b0;
            mem_memtoreg_reg <= 1'b0;
            mem_memread_reg  <= 1'b0;
            mem_memwrite_reg <= 1'b0;
            mem_dst_reg      <= '0;
            wb_regwrite_reg  <= 1'b0;
            wb_memtoreg_reg  <= 1'b0;
            wb_dst_reg       <= '0;
        end else begin
            if (bubble) begin
                ex_regwrite_reg <= 1'b0;
                ex_memtoreg_reg <= 1'b0;
                ex_memread_reg  <= 1'b0;
                ex_memwrite_reg <= 1'b0;
                ex_alusrc_reg   <= 1'b0;
                ex_aluop_reg    <= 2'b00;
                ex_rs_reg       <= '0;
                ex_rt_reg       <= '0;
                ex_dst_reg      <= '0;
            end else begin
                ex_regwrite_reg <= ctrl_i[B_REGWRITE];
                ex_memtoreg_reg <= ctrl_i[B_MEMTOREG];
                ex_memread_reg  <= ctrl_i[B_MEMREAD];
                ex_memwrite_reg <= ctrl_i[B_MEMWRITE];
                ex_alusrc_reg   <= ctrl_i[B_ALUSRC];
                ex_aluop_reg    <= ctrl_i[2:1];
                ex_rs_reg       <= rs_i;
                ex_rt_reg       <= rt_i;
                ex_dst_reg      <= id_dst;
            end
            mem_regwrite_reg <= ex_regwrite_reg;
            mem_memtoreg_reg <= ex_memtoreg_reg;
            mem_memread_reg  <= ex_memread_reg;
            mem_memwrite_reg <= ex_memwrite_reg;
            mem_dst_reg      <= ex_dst_reg;
            wb_regwrite_reg  <= mem_regwrite_reg;
            wb_memtoreg_reg  <= mem_memtoreg_reg;
            wb_dst_reg       <= mem_dst_reg;
        end
    end

    // Operand 0 is ALU A (rs), operand 1 is ALU B (rt); MEM result is newer, so it wins.
    logic [REG_W-1:0] ex_src   [2];
    logic [1:0]       fwd_sel  [2];

    assign ex_src[0] = ex_rs_reg;
    assign ex_src[1] = ex_rt_reg;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            always_comb begin
                fwd_sel[gi] = 2'b00;
                if (mem_regwrite_reg && (mem_dst_reg != '0) && (mem_dst_reg == ex_src[gi]))
                    fwd_sel[gi] = 2'b10;
                else if (wb_regwrite_reg && (wb_dst_reg != '0) && (wb_dst_reg == ex_src[gi]))
                    fwd_sel[gi] = 2'b01;
            end
        end
    endgenerate

    assign fwd_a_o        = fwd_sel[0];
    assign fwd_b_o        = fwd_sel[1];
    assign stall_o        = stall;
    assign pc_write_o     = !stall;
    assign ifid_write_o   = !stall;
    assign ex_alusrc_o    = ex_alusrc_reg;
    assign ex_aluop_o     = ex_aluop_reg;
    assign ex_rs_o        = ex_rs_reg;
    assign ex_rt_o        = ex_rt_reg;
    assign ex_dst_o       = ex_dst_reg;
    assign mem_memread_o  = mem_memread_reg;
    assign mem_memwrite_o = mem_memwrite_reg;
    assign mem_regwrite_o = mem_regwrite_reg;
    assign mem_dst_o      = mem_dst_reg;
    assign wb_regwrite_o  = wb_regwrite_reg;
    assign wb_memtoreg_o  = wb_memtoreg_reg;
    assign wb_dst_o       = wb_dst_reg;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Scoreboard bench for ctrl_pipe: stimulus queues expected values tagged with the cycle they
// are due; a negedge monitor pops and compares every entry that falls due.
module tb_ctrl_pipe;

    localparam int REG_W = 5;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [7:0]       ctrl_i;
    logic [REG_W-1:0] rs_i, rt_i, rd_i;
    logic             flush_i;
    logic             pc_write_o, ifid_write_o, stall_o, ex_alusrc_o;
    logic [1:0]       ex_aluop_o, fwd_a_o, fwd_b_o;
    logic [REG_W-1:0] ex_rs_o, ex_rt_o, ex_dst_o, mem_dst_o, wb_dst_o;
    logic             mem_memread_o, mem_memwrite_o, mem_regwrite_o;
    logic             wb_regwrite_o, wb_memtoreg_o;

    ctrl_pipe #(.REG_W(REG_W), .CTRL_W(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .ctrl_i(ctrl_i), .rs_i(rs_i), .rt_i(rt_i), .rd_i(rd_i),
        .flush_i(flush_i), .pc_write_o(pc_write_o), .ifid_write_o(ifid_write_o),
        .stall_o(stall_o), .ex_alusrc_o(ex_alusrc_o), .ex_aluop_o(ex_aluop_o),
        .ex_rs_o(ex_rs_o), .ex_rt_o(ex_rt_o), .ex_dst_o(ex_dst_o), .fwd_a_o(fwd_a_o),
        .fwd_b_o(fwd_b_o), .mem_memread_o(mem_memread_o), .mem_memwrite_o(mem_memwrite_o),
        .mem_regwrite_o(mem_regwrite_o), .mem_dst_o(mem_dst_o), .wb_regwrite_o(wb_regwrite_o),
        .wb_memtoreg_o(wb_memtoreg_o), .wb_dst_o(wb_dst_o)
    );

    always #5 clk_i = ~clk_i;

    localparam int F_STALL = 0,  F_PCW = 1,     F_IFIDW = 2,   F_EX_ALUSRC = 3, F_EX_ALUOP = 4;
    localparam int F_EX_RS = 5,  F_EX_RT = 6,   F_EX_DST = 7,  F_FWD_A = 8,     F_FWD_B = 9;
    localparam int F_MEM_RD = 10, F_MEM_WR = 11, F_MEM_RW = 12, F_MEM_DST = 13;
    localparam int F_WB_RW = 14, F_WB_M2R = 15, F_WB_DST = 16;

    typedef struct {
        int cyc;
        int field;
        int value;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    function automatic string name_of(input int f);
        case (f)
            F_STALL:     return "stall";
            F_PCW:       return "pc_write";
            F_IFIDW:     return "ifid_write";
            F_EX_ALUSRC: return "ex_alusrc";
            F_EX_ALUOP:  return "ex_aluop";
            F_EX_RS:     return "ex_rs";
            F_EX_RT:     return "ex_rt";
            F_EX_DST:    return "ex_dst";
            F_FWD_A:     return "fwd_a";
            F_FWD_B:     return "fwd_b";
            F_MEM_RD:    return "mem_memread";
            F_MEM_WR:    return "mem_memwrite";
            F_MEM_RW:    return "mem_regwrite";
            F_MEM_DST:   return "mem_dst";
            F_WB_RW:     return "wb_regwrite";
            F_WB_M2R:    return "wb_memtoreg";
            default:     return "wb_dst";
        endcase
    endfunction

    function automatic int read_dut(input int f);
        case (f)
            F_STALL:     return int'(stall_o);
            F_PCW:       return int'(pc_write_o);
            F_IFIDW:     return int'(ifid_write_o);
            F_EX_ALUSRC: return int'(ex_alusrc_o);
            F_EX_ALUOP:  return int'(ex_aluop_o);
            F_EX_RS:     return int'(ex_rs_o);
            F_EX_RT:     return int'(ex_rt_o);
            F_EX_DST:    return int'(ex_dst_o);
            F_FWD_A:     return int'(fwd_a_o);
            F_FWD_B:     return int'(fwd_b_o);
            F_MEM_RD:    return int'(mem_memread_o);
            F_MEM_WR:    return int'(mem_memwrite_o);
            F_MEM_RW:    return int'(mem_regwrite_o);
            F_MEM_DST:   return int'(mem_dst_o);
            F_WB_RW:     return int'(wb_regwrite_o);
            F_WB_M2R:    return int'(wb_memtoreg_o);
            default:     return int'(wb_dst_o);
        endcase
    endfunction

    // Monitor: compare every expectation that falls due in the current cycle.
    always @(negedge clk_i) begin
        int i;
        int act;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].cyc == cyc) begin
                act = read_dut(sb[i].field);
                n_tests++;
                if (act != sb[i].value) begin
                    n_fail++;
                    $display("[TB] FAIL cyc %0d %s: got %0d expected %0d",
                             cyc, name_of(sb[i].field), act, sb[i].value);
                end
                sb.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic exp(input int off, input int f, input int v);
        sb.push_back('{cyc + off, f, v});
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic id_in(input logic [7:0] c, input int s, input int t, input int d,
                         input logic f);
        ctrl_i  = c;
        rs_i    = REG_W'(s);
        rt_i    = REG_W'(t);
        rd_i    = REG_W'(d);
        flush_i = f;
        $display("[TB] cyc %0d rst=%0b ctrl=%h rs=%0d rt=%0d rd=%0d flush=%0b",
                 cyc, rst_i, c, s, t, d, f);
    endtask

    task automatic nops(input int n);
        for (int k = 0; k < n; k++) begin
            id_in(8'h00, 0, 0, 0, 1'b0);
            tick();
        end
    endtask

    task automatic exp_all_clear(input int off);
        exp(off, F_STALL, 0);     exp(off, F_PCW, 1);       exp(off, F_IFIDW, 1);
        exp(off, F_EX_ALUSRC, 0); exp(off, F_EX_ALUOP, 0);  exp(off, F_EX_RS, 0);
        exp(off, F_EX_RT, 0);     exp(off, F_EX_DST, 0);    exp(off, F_FWD_A, 0);
        exp(off, F_FWD_B, 0);     exp(off, F_MEM_RD, 0);    exp(off, F_MEM_WR, 0);
        exp(off, F_MEM_RW, 0);    exp(off, F_MEM_DST, 0);   exp(off, F_WB_RW, 0);
        exp(off, F_WB_M2R, 0);    exp(off, F_WB_DST, 0);
    endtask

    initial begin
        // Reset held two edges with an all-ones bundle in ID
        rst_i = 1'b0;
        id_in(8'hFF, 1, 2, 3, 1'b0);
        repeat (2) @(posedge clk_i);
        #1;
        exp_all_clear(0);
        n_tests++;
        if (stall_o !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset stall: got %0b expected 0", stall_o);
        end
        n_tests++;
        if (pc_write_o !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL reset pc_write: got %0b expected 1", pc_write_o);
        end
        n_tests++;
        if (wb_regwrite_o !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset wb_regwrite: got %0b expected 0", wb_regwrite_o);
        end
        rst_i = 1'b1;
        nops(1);

        // R-type through all stages
        id_in(8'h87, 1, 2, 3, 1'b0);
        exp(0, F_STALL, 0);
        exp(1, F_EX_ALUOP, 3); exp(1, F_EX_DST, 3); exp(1, F_EX_RS, 1); exp(1, F_EX_RT, 2);
        exp(1, F_EX_ALUSRC, 0);
        exp(2, F_MEM_RW, 1);   exp(2, F_MEM_DST, 3); exp(2, F_MEM_RD, 0);
        exp(3, F_WB_RW, 1);    exp(3, F_WB_DST, 3);  exp(3, F_WB_M2R, 0);
        tick();
        nops(4);

        // Load-use on rs: one stall cycle, bubble, then WB forward
        id_in(8'hE8, 6, 5, 0, 1'b0);
        exp(1, F_EX_RT, 5); exp(1, F_EX_DST, 5); exp(1, F_EX_ALUSRC, 1);
        tick();
        id_in(8'h87, 5, 7, 8, 1'b0);
        #1;
        n_tests++;
        if (stall_o !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL load-use stall: got %0b expected 1", stall_o);
        end
        exp(0, F_STALL, 1); exp(0, F_PCW, 0); exp(0, F_IFIDW, 0);
        exp(1, F_EX_ALUOP, 0); exp(1, F_EX_RS, 0); exp(1, F_EX_DST, 0);
        tick();
        exp(0, F_STALL, 0); exp(0, F_PCW, 1); exp(0, F_MEM_RD, 1); exp(0, F_MEM_DST, 5);
        exp(1, F_EX_RS, 5); exp(1, F_FWD_A, 1); exp(1, F_FWD_B, 0); exp(1, F_WB_M2R, 1);
        tick();
        nops(4);

        // Load-use on rt only, then B-side WB forward
        id_in(8'hE8, 0, 12, 0, 1'b0);
        tick();
        id_in(8'h87, 1, 12, 13, 1'b0);
        exp(0, F_STALL, 1);
        tick();
        exp(0, F_STALL, 0);
        exp(1, F_FWD_B, 1); exp(1, F_FWD_A, 0);
        tick();
        nops(4);

        // Load into r0 never stalls
        id_in(8'hE8, 0, 0, 0, 1'b0);
        tick();
        id_in(8'h87, 0, 0, 1, 1'b0);
        exp(0, F_STALL, 0); exp(0, F_PCW, 1);
        tick();
        nops(4);

        // MEM forward on both operands, then mixed MEM/WB forward
        id_in(8'h87, 1, 2, 4, 1'b0);
        tick();
        id_in(8'h87, 4, 4, 9, 1'b0);
        exp(1, F_FWD_A, 2); exp(1, F_FWD_B, 2);
        tick();
        id_in(8'h87, 4, 9, 0, 1'b0);
        exp(1, F_FWD_A, 1); exp(1, F_FWD_B, 2);
        tick();
        nops(4);

        // Destination r0 never forwards
        id_in(8'h87, 1, 2, 0, 1'b0);
        tick();
        id_in(8'h87, 0, 0, 5, 1'b0);
        exp(1, F_FWD_A, 0); exp(1, F_FWD_B, 0);
        tick();
        nops(4);

        // MEM and WB both match: MEM wins
        id_in(8'h87, 1, 2, 10, 1'b0);
        tick();
        id_in(8'h87, 1, 2, 10, 1'b0);
        tick();
        id_in(8'h87, 10, 10, 11, 1'b0);
        exp(1, F_FWD_A, 2); exp(1, F_FWD_B, 2);
        tick();
        nops(4);

        // Flush turns the ID instruction into a bubble
        id_in(8'h87, 1, 2, 3, 1'b1);
        exp(1, F_EX_ALUOP, 0); exp(1, F_EX_DST, 0); exp(1, F_EX_RS, 0); exp(1, F_EX_RT, 0);
        exp(2, F_MEM_RW, 0);   exp(3, F_WB_RW, 0);
        tick();
        nops(4);

        // Flush masks a load-use hazard
        id_in(8'hE8, 0, 6, 0, 1'b0);
        tick();
        id_in(8'h87, 6, 6, 3, 1'b1);
        exp(0, F_STALL, 0); exp(0, F_PCW, 1); exp(1, F_EX_RS, 0); exp(1, F_EX_ALUOP, 0);
        tick();
        nops(4);

        // Mid-run reset with sw, lw, R-type in flight
        id_in(8'h18, 1, 2, 0, 1'b0);
        tick();
        id_in(8'hE8, 3, 4, 0, 1'b0);
        tick();
        id_in(8'h87, 5, 6, 7, 1'b0);
        tick();
        exp(0, F_MEM_RD, 1); exp(0, F_WB_RW, 0); exp(0, F_EX_DST, 7);
        rst_i = 1'b0;
        id_in(8'hFF, 4, 4, 4, 1'b0);
        exp_all_clear(1);
        tick();
        rst_i = 1'b1;
        id_in(8'h00, 0, 0, 0, 1'b0);
        exp(1, F_WB_RW, 0); exp(2, F_WB_RW, 0); exp(3, F_WB_RW, 0);
        exp(1, F_MEM_RW, 0); exp(2, F_WB_DST, 0);
        tick();
        nops(6);
        n_tests++;
        if (wb_regwrite_o !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL post-reset wb_regwrite: got %0b expected 0", wb_regwrite_o);
        end

        while (sb.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL pending %s: got never-checked expected %0d due cyc %0d",
                     name_of(sb[0].field), sb[0].value, sb[0].cyc);
            sb.delete(0);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
